qam_bit_serializer: RTL and testbench

QAM_BIT_SERIALIZER -- requirements
Module: qam_bit_serializer

---
 rtl/qam_bit_serializer_pkg.sv | 24 ++
 rtl/qam_bit_serializer_if.sv | 37 +++
 rtl/qam_sync_fifo.sv | 67 ++++++
 rtl/qam_bit_serializer.sv | 130 +++++++++++++
 tb/tb_qam_bit_serializer.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/qam_bit_serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : qam_pkg
//  Description : Shared FSM state type, default sizes and width helper for
//                the QAM bit serializer.
//  Revision    : 1.0 - initial release
// ============================================================================
package qam_pkg;

  localparam int QAM_DATA_W     = 8;
  localparam int QAM_FIFO_DEPTH = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } qam_state_t;

  // Counter width that stays legal when the count range collapses to one value
  function automatic int qam_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/qam_bit_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : qam_bit_serializer_if
//  Description : Word-in / bit-out bundle between a word source and the
//                serializer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface qam_bit_serializer_if
  import qam_pkg::*;
#(
  parameter int DATA_W     = QAM_DATA_W,
  parameter int FIFO_DEPTH = QAM_FIFO_DEPTH
) ();

  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_W-1:0]  in_data;
  logic               in_valid;
  logic               in_ready;
  logic               en;
  logic               bit_out;
  logic               bit_valid;
  logic               word_done;
  logic [LEVEL_W-1:0] fifo_level;

  modport master (
    output in_data, in_valid, en,
    input  in_ready, bit_out, bit_valid, word_done, fifo_level
  );

  modport slave (
    input  in_data, in_valid, en,
    output in_ready, bit_out, bit_valid, word_done, fifo_level
  );

endinterface
`default_nettype wire

// File: rtl/qam_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : qam_sync_fifo
//  Description : Single-clock word FIFO with occupancy count; power-of-two
//                depth so pointers wrap naturally.
//  Revision    : 1.0 - initial release
// ============================================================================
module qam_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [DATA_W-1:0]            push_data,
  input  logic                         pop,
  output logic [DATA_W-1:0]            pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH):0]       level
);

  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int LEVEL_W = ADDR_W + 1;

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0]  r_wr_ptr;
  logic [ADDR_W-1:0]  r_rd_ptr;
  logic [LEVEL_W-1:0] r_level;
  logic               w_do_push;
  logic               w_do_pop;

  assign full      = (r_level == LEVEL_W'(DEPTH));
  assign empty     = (r_level == '0);
  assign level     = r_level;
  assign pop_data  = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      if (w_do_push && !w_do_pop) begin
        r_level <= r_level + LEVEL_W'(1);
      end else if (!w_do_push && w_do_pop) begin
        r_level <= r_level - LEVEL_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/qam_bit_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : qam_bit_serializer
//  Description : Buffers words and streams them MSB first, one bit per
//                SYM_DIV enabled cycles, with zero-gap back-to-back words.
//  Revision    : 1.0 - initial release
// ============================================================================
module qam_bit_serializer
  import qam_pkg::*;
#(
  parameter int DATA_W     = QAM_DATA_W,
  parameter int FIFO_DEPTH = QAM_FIFO_DEPTH,
  parameter int SYM_DIV    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  qam_bit_serializer_if.slave  bus
);

  localparam int HOLD_W  = qam_cnt_w(SYM_DIV);
  localparam int BIT_W   = qam_cnt_w(DATA_W);
  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [HOLD_W-1:0] c_HOLD_LAST = HOLD_W'(SYM_DIV - 1);
  localparam logic [BIT_W-1:0]  c_BIT_LAST  = BIT_W'(DATA_W - 1);

  qam_state_t         r_state;
  qam_state_t         w_state_nxt;
  logic [DATA_W-1:0]  r_shift;
  logic [DATA_W-1:0]  w_shift_nxt;
  logic [HOLD_W-1:0]  r_hold;
  logic [HOLD_W-1:0]  w_hold_nxt;
  logic [BIT_W-1:0]   r_bit;
  logic [BIT_W-1:0]   w_bit_nxt;
  logic               w_pop;
  logic               w_push;
  logic               w_full;
  logic               w_empty;
  logic               w_word_done;
  logic [DATA_W-1:0]  w_fifo_data;
  logic [LEVEL_W-1:0] w_level;

  // Held low throughout reset so no word is taken while the block is cleared
  assign bus.in_ready = rst_n && !w_full;
  assign w_push       = bus.in_valid && bus.in_ready;

  qam_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (bus.in_data),
    .pop       (w_pop),
    .pop_data  (w_fifo_data),
    .full      (w_full),
    .empty     (w_empty),
    .level     (w_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_hold  <= '0;
      r_bit   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_hold  <= w_hold_nxt;
      r_bit   <= w_bit_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_hold_nxt  = r_hold;
    w_bit_nxt   = r_bit;
    w_pop       = 1'b0;
    w_word_done = 1'b0;

    case (r_state)
      IDLE: begin
        if (bus.en && !w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_fifo_data;
          w_hold_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.en) begin
          if (r_hold == c_HOLD_LAST) begin
            w_hold_nxt = '0;
            if (r_bit == c_BIT_LAST) begin
              w_word_done = 1'b1;
              w_bit_nxt   = '0;
              if (!w_empty) begin
                w_pop       = 1'b1;
                w_shift_nxt = w_fifo_data;
              end else begin
                // Clearing the shifter keeps bit_out low while idle
                w_shift_nxt = '0;
                w_state_nxt = IDLE;
              end
            end else begin
              w_bit_nxt   = r_bit + BIT_W'(1);
              w_shift_nxt = {r_shift[DATA_W-2:0], 1'b0};
            end
          end else begin
            w_hold_nxt = r_hold + HOLD_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.bit_out    = r_shift[DATA_W-1];
  assign bus.bit_valid  = (r_state == SHIFT);
  assign bus.word_done  = w_word_done;
  assign bus.fifo_level = w_level;

endmodule
`default_nettype wire

// File: tb/tb_qam_bit_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qam_bit_serializer
//  Description : Drives a SYM_DIV=1 and a SYM_DIV=3 serializer side by side
//                against a queue-based bit-stream model plus literal vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_qam_bit_serializer;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int LEVEL_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int SYM_A      = 1;
  localparam int SYM_B      = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              en = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  qam_bit_serializer_if #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) if_a ();
  qam_bit_serializer_if #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) if_b ();

  assign if_a.in_data  = in_data;
  assign if_a.in_valid = in_valid;
  assign if_a.en       = en;
  assign if_b.in_data  = in_data;
  assign if_b.in_valid = in_valid;
  assign if_b.en       = en;

  qam_bit_serializer #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .SYM_DIV(SYM_A)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a)
  );

  qam_bit_serializer #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .SYM_DIV(SYM_B)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b)
  );

  logic               bv  [2];
  logic               bo  [2];
  logic               wd  [2];
  logic               rdy [2];
  logic [LEVEL_W-1:0] lvl [2];

  assign bv[0]  = if_a.bit_valid;
  assign bo[0]  = if_a.bit_out;
  assign wd[0]  = if_a.word_done;
  assign rdy[0] = if_a.in_ready;
  assign lvl[0] = if_a.fifo_level;
  assign bv[1]  = if_b.bit_valid;
  assign bo[1]  = if_b.bit_out;
  assign wd[1]  = if_b.word_done;
  assign rdy[1] = if_b.in_ready;
  assign lvl[1] = if_b.fifo_level;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: buffered words plus the remaining per-cycle bits of the word on air
  logic [DATA_W-1:0] fq   [2][$];
  bit                pend [2][$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        fq[k].delete();
        pend[k].delete();
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        automatic bit acc = in_valid && (fq[k].size() < FIFO_DEPTH);
        automatic int div = (k == 0) ? SYM_A : SYM_B;
        if (en) begin
          if (pend[k].size() > 0) void'(pend[k].pop_front());
          if (pend[k].size() == 0 && fq[k].size() > 0) begin
            automatic logic [DATA_W-1:0] w = fq[k].pop_front();
            for (int b = DATA_W - 1; b >= 0; b--)
              for (int h = 0; h < div; h++) pend[k].push_back(w[b]);
          end
        end
        if (acc) fq[k].push_back(in_data);
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      automatic bit exp_v  = pend[k].size() > 0;
      automatic bit exp_b  = exp_v ? pend[k][0] : 1'b0;
      automatic bit exp_wd = en && rst_n && (pend[k].size() == 1);
      automatic bit exp_r  = rst_n && (fq[k].size() < FIFO_DEPTH);
      check($sformatf("dut%0d.bit_valid", k), 32'(bv[k]), 32'(exp_v));
      check($sformatf("dut%0d.bit_out", k), 32'(bo[k]), 32'(exp_b));
      check($sformatf("dut%0d.word_done", k), 32'(wd[k]), 32'(exp_wd));
      check($sformatf("dut%0d.in_ready", k), 32'(rdy[k]), 32'(exp_r));
      check($sformatf("dut%0d.fifo_level", k), 32'(lvl[k]), fq[k].size());
    end
  end

  task automatic push_words(input logic [DATA_W-1:0] ws [6], input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = ws[i];
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic push1(input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] ws [6];
    ws = '{w, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    push_words(ws, 1);
  endtask

  // Waits for the first live bit on DUT k, then records n consecutive cycles
  task automatic capture(input int k, input int n, output logic [31:0] bits,
                         output logic [31:0] vals, output logic [31:0] dones,
                         output int lat);
    bits = '0; vals = '0; dones = '0;
    @(negedge clk);
    lat = 1;
    while (!bv[k] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!bv[k]) check("capture_timeout", 32'(lat), 32'd0);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      bits  = {bits[30:0], bo[k]};
      vals  = {vals[30:0], bv[k]};
      dones = {dones[30:0], wd[k]};
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!(!bv[0] && !bv[1] && lvl[0] == 0 && lvl[1] == 0) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("idle_timeout", 32'(bv[0] | bv[1]), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0]       bits, vals, dones;
    int                lat;
    logic [DATA_W-1:0] ws [6];
    int                held;

    repeat (3) @(posedge clk);
    #1;
    check("rst.bit_valid", 32'(bv[0] | bv[1]), 32'd0);
    check("rst.in_ready_low", 32'(rdy[0] | rdy[1]), 32'd0);
    check("rst.level", 32'(lvl[0] | lvl[1]), 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst.in_ready", 32'(rdy[0] & rdy[1]), 32'd1);
    en = 1'b1;

    // Single word, SYM_DIV=1
    push1(8'hA5);
    capture(0, 8, bits, vals, dones, lat);
    check("a5.latency", 32'(lat), 32'd2);
    check("a5.bits", bits, 32'h0000_00A5);
    check("a5.valid", vals, 32'h0000_00FF);
    check("a5.done", dones, 32'h0000_0001);
    @(negedge clk);
    check("a5.idle_after", 32'(bv[0]), 32'd0);
    wait_idle();

    // Back-to-back words with no gap
    ws = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    push_words(ws, 2);
    capture(0, 16, bits, vals, dones, lat);
    check("ff00.bits", bits, 32'h0000_FF00);
    check("ff00.valid", vals, 32'h0000_FFFF);
    check("ff00.done", dones, 32'h0000_0101);
    @(negedge clk);
    check("ff00.idle_after", 32'(bv[0]), 32'd0);
    wait_idle();

    // Slow symbol rate on the SYM_DIV=3 instance
    push1(8'h80);
    capture(1, 24, bits, vals, dones, lat);
    check("div3.latency", 32'(lat), 32'd2);
    check("div3.bits", bits, 32'h00E0_0000);
    check("div3.valid", vals, 32'h00FF_FFFF);
    check("div3.done", dones, 32'h0000_0001);
    @(negedge clk);
    check("div3.idle_after", 32'(bv[1]), 32'd0);
    wait_idle();

    // Overfill while stalled; the refused 0x77 arrives on a full+pop cycle
    en = 1'b0;
    ws = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    push_words(ws, 6);
    check("fill.level_a", 32'(lvl[0]), 32'd4);
    check("fill.level_b", 32'(lvl[1]), 32'd4);
    check("fill.ready", 32'(rdy[0] | rdy[1]), 32'd0);
    en       = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h77;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    capture(0, 32, bits, vals, dones, lat);
    check("fill.bits", bits, 32'h1122_3344);
    check("fill.valid", vals, 32'hFFFF_FFFF);
    check("fill.done", dones, 32'h0101_0101);
    @(negedge clk);
    check("fill.idle_after", 32'(bv[0]), 32'd0);
    wait_idle();

    // Stall mid-word
    push1(8'h3C);
    capture(0, 3, bits, vals, dones, lat);
    #2;
    en   = 1'b0;
    held = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bo[0] === 1'b1 && bv[0] === 1'b1) held++;
    end
    check("stall.held", 32'(held), 32'd5);
    #2;
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bits  = {bits[30:0], bo[0]};
      dones = {dones[30:0], wd[0]};
    end
    check("stall.bits", bits & 32'hFF, 32'h0000_003C);
    check("stall.done", dones & 32'hFF, 32'h0000_0001);
    wait_idle();

    // Reset mid-word with words queued
    ws = '{8'hC3, 8'h5A, 8'h96, 8'h00, 8'h00, 8'h00};
    push_words(ws, 3);
    capture(0, 3, bits, vals, dones, lat);
    check("mid.level_before", 32'(lvl[0]), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid.bit_valid", 32'(bv[0] | bv[1]), 32'd0);
    check("mid.bit_out", 32'(bo[0] | bo[1]), 32'd0);
    check("mid.level", 32'(lvl[0] | lvl[1]), 32'd0);
    check("mid.in_ready", 32'(rdy[0] | rdy[1]), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("mid.ready_after", 32'(rdy[0] & rdy[1]), 32'd1);
    held = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bv[0] || bv[1]) held++;
    end
    check("mid.silent", 32'(held), 32'd0);
    push1(8'h01);
    capture(0, 8, bits, vals, dones, lat);
    check("mid.new_bits", bits, 32'h0000_0001);
    check("mid.new_valid", vals, 32'h0000_00FF);
    check("mid.new_done", dones, 32'h0000_0001);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
